// File: rtl/lsu_buffered.sv
// Load/store unit: issues local DMEM accesses combinationally and queues remote
// requests in a credit-gated FIFO; also tracks LR reservations and exceptions.
module lsu_buffered #(
    parameter int unsigned data_width_p      = 32,
    parameter int unsigned dmem_size_p       = 1024,
    parameter int unsigned fifo_els_p        = 4,
    parameter int unsigned max_out_credits_p = 16,
    parameter int unsigned low_dmem_limit_p  = 'h400,
    parameter int unsigned high_dmem_base_p  = 'h3F400
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic                                   v_i,
    input  logic                                   is_load_i,
    input  logic                                   is_store_i,
    input  logic                                   is_amo_i,
    input  logic                                   is_lr_i,
    input  logic [1:0]                             size_i,
    input  logic [data_width_p-1:0]                rs1_i,
    input  logic [data_width_p-1:0]                rs2_i,
    input  logic [data_width_p-1:0]                offset_i,
    input  logic [4:0]                             rd_i,
    output logic                                   ready_o,
    output logic                                   dmem_v_o,
    output logic                                   dmem_w_o,
    output logic [$clog2(dmem_size_p)-1:0]         dmem_addr_o,
    output logic [data_width_p-1:0]                dmem_data_o,
    output logic [data_width_p/8-1:0]              dmem_mask_o,
    output logic                                   remote_req_v_o,
    input  logic                                   remote_req_yumi_i,
    output logic [data_width_p-1:0]                remote_req_addr_o,
    output logic [data_width_p-1:0]                remote_req_data_o,
    output logic [data_width_p/8-1:0]              remote_req_mask_o,
    output logic                                   remote_req_write_o,
    output logic                                   remote_req_amo_o,
    output logic [4:0]                             remote_req_reg_id_o,
    input  logic                                   credit_return_i,
    input  logic                                   clear_reservation_i,
    output logic                                   reservation_v_o,
    output logic [$clog2(dmem_size_p)-1:0]         reservation_addr_o,
    output logic                                   exception_v_o,
    output logic [1:0]                             exception_cause_o,
    output logic [$clog2(max_out_credits_p+1)-1:0] out_credits_o,
    output logic                                   fence_busy_o
);
    localparam int unsigned dmem_addr_w_lp = $clog2(dmem_size_p);
    localparam int unsigned mask_w_lp      = data_width_p / 8;
    localparam int unsigned credit_w_lp    = $clog2(max_out_credits_p + 1);
    localparam int unsigned ptr_w_lp       = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
    localparam int unsigned cnt_w_lp       = $clog2(fifo_els_p + 1);

    localparam logic [data_width_p-1:0] low_lim_lp   = data_width_p'(low_dmem_limit_p);
    localparam logic [data_width_p-1:0] high_base_lp = data_width_p'(high_dmem_base_p);
    localparam logic [data_width_p-1:0] high_top_lp  = data_width_p'(32'h3FFFF);
    localparam logic [credit_w_lp-1:0]  max_cred_lp  = credit_w_lp'(max_out_credits_p);
    localparam logic [cnt_w_lp-1:0]     fifo_els_lp  = cnt_w_lp'(fifo_els_p);

    typedef struct packed {
        logic [data_width_p-1:0] addr;
        logic [data_width_p-1:0] data;
        logic [mask_w_lp-1:0]    mask;
        logic                    write;
        logic                    amo;
        logic [4:0]              reg_id;
    } req_t;

    req_t                      mem_q [fifo_els_p];
    req_t                      mem_d [fifo_els_p];
    logic [ptr_w_lp-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [cnt_w_lp-1:0]       cnt_q, cnt_d;
    logic [credit_w_lp-1:0]    credits_q, credits_d;
    logic                      res_v_q, res_v_d;
    logic [dmem_addr_w_lp-1:0] res_addr_q, res_addr_d;
    logic                      exc_v_q, exc_v_d;
    logic [1:0]                exc_cause_q, exc_cause_d;

    logic [data_width_p-1:0]   addr;
    logic [data_width_p-1:0]   st_data;
    logic [mask_w_lp-1:0]      st_mask;
    logic                      is_local, misaligned, need_enq, can_enq, enq, deq, accept, exc_hit;
    logic [1:0]                exc_cause;
    req_t                      new_req;

    function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(fifo_els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        addr       = rs1_i + offset_i;
        is_local   = (addr < low_lim_lp) || ((addr >= high_base_lp) && (addr <= high_top_lp));
        misaligned = ((size_i == 2'd1) && addr[0]) || (size_i[1] && (addr[1:0] != 2'b00));
        st_data    = rs2_i;
        st_mask    = '1;
        if (size_i == 2'd0) begin
            for (int i = 0; i < int'(mask_w_lp); i++) st_data[8*i +: 8] = rs2_i[7:0];
            st_mask = mask_w_lp'(1) << addr[1:0];
        end else if (size_i == 2'd1) begin
            for (int i = 0; i < int'(mask_w_lp); i++)
                st_data[8*i +: 8] = (i % 2 == 1) ? rs2_i[15:8] : rs2_i[7:0];
            st_mask = mask_w_lp'(3) << {addr[1], 1'b0};
        end
    end

    // Handshake: an op is taken when v_i & ready_o; ready_o drops only for a
    // remote load/store/amo that finds the FIFO full (no same-cycle pop) or no credits.
    always_comb begin
        need_enq  = v_i && !is_local && !misaligned && (is_load_i || is_store_i || is_amo_i);
        can_enq   = ((cnt_q != fifo_els_lp) || remote_req_yumi_i) && (credits_q != '0);
        ready_o   = !need_enq || can_enq;
        enq       = need_enq && can_enq;
        deq       = remote_req_yumi_i && (cnt_q != '0);
        accept    = v_i && ready_o;
        exc_hit   = accept && (misaligned || (is_local && is_amo_i) || (!is_local && is_lr_i));
        exc_cause = misaligned ? 2'd1 : (is_amo_i ? 2'd2 : 2'd3);
        new_req   = '{addr: addr, data: st_data, mask: st_mask, write: is_store_i,
                      amo: is_amo_i, reg_id: rd_i};
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (enq) begin
            mem_d[wr_ptr_q] = new_req;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (deq) rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({enq, deq})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        case ({enq, credit_return_i})
            2'b10:   credits_d = credits_q - 1'b1;
            2'b01:   credits_d = credits_q + 1'b1;
            default: credits_d = credits_q;
        endcase
        exc_v_d     = exc_hit;
        exc_cause_d = exc_hit ? exc_cause : 2'd0;
        res_v_d     = res_v_q;
        res_addr_d  = res_addr_q;
        // A new LR takes priority over any same-cycle kill.
        if (v_i && is_lr_i && is_local && !misaligned) begin
            res_v_d    = 1'b1;
            res_addr_d = dmem_addr_o;
        end else if (clear_reservation_i ||
                     (v_i && is_store_i && is_local && !misaligned && res_v_q &&
                      (dmem_addr_o == res_addr_q))) begin
            res_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < int'(fifo_els_p); i++) mem_q[i] <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            credits_q   <= max_cred_lp;
            res_v_q     <= 1'b0;
            res_addr_q  <= '0;
            exc_v_q     <= 1'b0;
            exc_cause_q <= 2'd0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            credits_q   <= credits_d;
            res_v_q     <= res_v_d;
            res_addr_q  <= res_addr_d;
            exc_v_q     <= exc_v_d;
            exc_cause_q <= exc_cause_d;
        end
    end

    assign dmem_v_o            = v_i && is_local && (is_load_i || is_store_i || is_lr_i) && !misaligned;
    assign dmem_w_o            = is_store_i;
    assign dmem_addr_o         = addr[2 +: dmem_addr_w_lp];
    assign dmem_data_o         = st_data;
    assign dmem_mask_o         = st_mask;
    assign remote_req_v_o      = (cnt_q != '0);
    assign remote_req_addr_o   = mem_q[rd_ptr_q].addr;
    assign remote_req_data_o   = mem_q[rd_ptr_q].data;
    assign remote_req_mask_o   = mem_q[rd_ptr_q].mask;
    assign remote_req_write_o  = mem_q[rd_ptr_q].write;
    assign remote_req_amo_o    = mem_q[rd_ptr_q].amo;
    assign remote_req_reg_id_o = mem_q[rd_ptr_q].reg_id;
    assign reservation_v_o     = res_v_q;
    assign reservation_addr_o  = res_addr_q;
    assign exception_v_o       = exc_v_q;
    assign exception_cause_o   = exc_cause_q;
    assign out_credits_o       = credits_q;
    assign fence_busy_o        = (credits_q != max_cred_lp) || (cnt_q != '0);

    a_no_yumi_empty: assert property (@(posedge clk_i) disable iff (reset_i)
        !(remote_req_yumi_i && (cnt_q == '0)));
    a_no_return_at_max: assert property (@(posedge clk_i) disable iff (reset_i)
        !(credit_return_i && (credits_q == max_cred_lp)));
    a_no_enq_at_zero: assert property (@(posedge clk_i) disable iff (reset_i)
        !(enq && (credits_q == '0)));
endmodule

// File: tb/tb_lsu_buffered.sv
// Bench for lsu_buffered: directed steps then random ops, each cycle compared
// against a queue/arithmetic model of the unit.
module tb_lsu_buffered;
    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        v_i, is_load_i, is_store_i, is_amo_i, is_lr_i;
    logic [1:0]  size_i;
    logic [31:0] rs1_i, rs2_i, offset_i;
    logic [4:0]  rd_i;
    logic        ready_o, dmem_v_o, dmem_w_o;
    logic [9:0]  dmem_addr_o;
    logic [31:0] dmem_data_o;
    logic [3:0]  dmem_mask_o;
    logic        remote_req_v_o, remote_req_yumi_i;
    logic [31:0] remote_req_addr_o, remote_req_data_o;
    logic [3:0]  remote_req_mask_o;
    logic        remote_req_write_o, remote_req_amo_o;
    logic [4:0]  remote_req_reg_id_o;
    logic        credit_return_i, clear_reservation_i, reservation_v_o;
    logic [9:0]  reservation_addr_o;
    logic        exception_v_o;
    logic [1:0]  exception_cause_o;
    logic [4:0]  out_credits_o;
    logic        fence_busy_o;

    always #5 clk_i = ~clk_i;

    lsu_buffered dut (
        .clk_i(clk_i), .reset_i(reset_i), .v_i(v_i), .is_load_i(is_load_i),
        .is_store_i(is_store_i), .is_amo_i(is_amo_i), .is_lr_i(is_lr_i), .size_i(size_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .offset_i(offset_i), .rd_i(rd_i), .ready_o(ready_o),
        .dmem_v_o(dmem_v_o), .dmem_w_o(dmem_w_o), .dmem_addr_o(dmem_addr_o),
        .dmem_data_o(dmem_data_o), .dmem_mask_o(dmem_mask_o), .remote_req_v_o(remote_req_v_o),
        .remote_req_yumi_i(remote_req_yumi_i), .remote_req_addr_o(remote_req_addr_o),
        .remote_req_data_o(remote_req_data_o), .remote_req_mask_o(remote_req_mask_o),
        .remote_req_write_o(remote_req_write_o), .remote_req_amo_o(remote_req_amo_o),
        .remote_req_reg_id_o(remote_req_reg_id_o), .credit_return_i(credit_return_i),
        .clear_reservation_i(clear_reservation_i), .reservation_v_o(reservation_v_o),
        .reservation_addr_o(reservation_addr_o), .exception_v_o(exception_v_o),
        .exception_cause_o(exception_cause_o), .out_credits_o(out_credits_o),
        .fence_busy_o(fence_busy_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: pending remote requests {addr, data, mask, write, amo, rd}.
    logic [74:0] exp_q[$];
    int          credits_m;
    bit          res_v_m;
    int          res_addr_m;
    bit          exc_v_m;
    int          exc_cause_m;

    task automatic chk(input string tag, input logic [74:0] obs, input logic [74:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        credits_m = 16;
        res_v_m   = 0;
        exc_v_m   = 0;
    endtask

    // op: 0 none, 1 load, 2 store, 3 amo, 4 lr
    task automatic step(input int op, input int sz, input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [31:0] off, input int rd, input bit yumi, input bit cret,
                        input bit clr);
        logic [31:0] a, d;
        logic [3:0]  m;
        bit          loc, mis, need, rdy, acc, issue;
        @(negedge clk_i);
        v_i = (op != 0); is_load_i = (op == 1); is_store_i = (op == 2);
        is_amo_i = (op == 3); is_lr_i = (op == 4); size_i = 2'(sz);
        rs1_i = rs1; rs2_i = rs2; offset_i = off; rd_i = 5'(rd);
        remote_req_yumi_i = yumi; credit_return_i = cret; clear_reservation_i = clr;
        #1;
        a   = rs1 + off;
        loc = (a < 32'h400) || (a >= 32'h3F400 && a <= 32'h3FFFF);
        mis = (sz == 1 && (a % 2) != 0) || (sz >= 2 && (a % 4) != 0);
        if (sz == 0)      begin d = (rs2 % 256) * 32'h01010101;   m = 4'(1 << (a % 4)); end
        else if (sz == 1) begin d = (rs2 % 65536) * 32'h00010001; m = ((a % 4) >= 2) ? 4'b1100 : 4'b0011; end
        else              begin d = rs2;                          m = 4'b1111; end
        need  = (op >= 1 && op <= 3) && !loc && !mis;
        rdy   = !need || ((exp_q.size() < 4 || yumi) && credits_m > 0);
        issue = (op == 1 || op == 2 || op == 4) && loc && !mis;

        chk("exc_v", exception_v_o, exc_v_m);
        if (exc_v_m) chk("exc_cause", exception_cause_o, exc_cause_m);
        chk("credits", out_credits_o, credits_m);
        chk("fence_busy", fence_busy_o, (credits_m != 16) || (exp_q.size() != 0));
        chk("res_v", reservation_v_o, res_v_m);
        if (res_v_m) chk("res_addr", reservation_addr_o, res_addr_m);
        chk("rreq_v", remote_req_v_o, exp_q.size() != 0);
        if (exp_q.size() != 0)
            chk("rreq_head", {remote_req_addr_o, remote_req_data_o, remote_req_mask_o,
                remote_req_write_o, remote_req_amo_o, remote_req_reg_id_o}, exp_q[0]);
        if (op != 0) chk("ready", ready_o, rdy);
        chk("dmem_v", dmem_v_o, issue);
        if (issue) begin
            chk("dmem_w", dmem_w_o, op == 2);
            chk("dmem_addr", dmem_addr_o, (a / 4) % 1024);
            chk("dmem_data", dmem_data_o, d);
            chk("dmem_mask", dmem_mask_o, m);
        end

        acc     = (op != 0) && rdy;
        exc_v_m = acc && (mis || (loc && op == 3) || (!loc && op == 4));
        exc_cause_m = mis ? 1 : (op == 3 ? 2 : 3);
        if (yumi) void'(exp_q.pop_front());
        if (acc && need) begin
            exp_q.push_back({a, d, m, op == 2, op == 3, 5'(rd)});
            credits_m--;
        end
        if (cret) credits_m++;
        if (op == 4 && loc && !mis) begin
            res_v_m = 1; res_addr_m = (a / 4) % 1024;
        end else if (clr || (op == 2 && loc && !mis && res_v_m && res_addr_m == (a / 4) % 1024)) begin
            res_v_m = 0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Drain the FIFO and return outstanding credits.
    task automatic settle();
        for (int i = 0; i < 40 && (exp_q.size() != 0 || credits_m < 16); i++)
            step(0, 0, 0, 0, 0, 0, exp_q.size() != 0, credits_m < 16, 0);
        chk("settled", {exp_q.size() == 0, credits_m == 16}, 2'b11);
    endtask

    initial begin
        int op, sz, cls;
        logic [31:0] a, off;
        reset_i = 1'b1;
        v_i = 0; is_load_i = 0; is_store_i = 0; is_amo_i = 0; is_lr_i = 0; size_i = 0;
        rs1_i = 0; rs2_i = 0; offset_i = 0; rd_i = 0;
        remote_req_yumi_i = 0; credit_return_i = 0; clear_reservation_i = 0;
        model_reset();
        repeat (2) @(negedge clk_i);
        chk("rst_rreq_v", remote_req_v_o, 1'b0);
        chk("rst_credits", out_credits_o, 5'd16);
        chk("rst_fence", fence_busy_o, 1'b0);
        chk("rst_res_v", reservation_v_o, 1'b0);
        chk("rst_exc_v", exception_v_o, 1'b0);
        chk("rst_cause", exception_cause_o, 2'd0);
        reset_i = 1'b0;

        // Byte store to 0x103.
        step(2, 0, 32'h100, 32'hAB, 32'd3, 1, 0, 0, 0);
        chk("bst_ready", ready_o, 1'b1);
        chk("bst_w", dmem_w_o, 1'b1);
        chk("bst_addr", dmem_addr_o, 10'h40);
        chk("bst_mask", dmem_mask_o, 4'b1000);
        chk("bst_data", dmem_data_o, 32'hABABABAB);

        // High-window word load, then remote load.
        step(1, 2, 32'h3F400, 0, 32'd4, 2, 0, 0, 0);
        chk("hi_dmem_v", dmem_v_o, 1'b1);
        chk("hi_addr", dmem_addr_o, 10'h101);
        step(1, 2, 32'h80000000, 0, 0, 7, 0, 0, 0);
        chk("rem_dmem_v", dmem_v_o, 1'b0);
        idle(1);
        chk("rem_v", remote_req_v_o, 1'b1);
        chk("rem_credits", out_credits_o, 5'd15);
        settle();

        // Fill FIFO with yumi low; 5th stalls, then pop+push accepted.
        for (int i = 0; i < 5; i++)
            step(2, 2, 32'h80000100 + 32'(4 * i), 32'h1000 + 32'(i), 0, 10 + i, 0, 0, 0);
        chk("full_stall", ready_o, 1'b0);
        step(2, 2, 32'h80000200, 32'h55, 0, 20, 1, 0, 0);
        chk("full_yumi_acc", ready_o, 1'b1);
        settle();

        // Exhaust all credits while the FIFO drains.
        for (int i = 0; i < 16; i++)
            step(1, 2, 32'h90000000 + 32'(16 * i), 0, 0, i, exp_q.size() != 0, 0, 0);
        step(1, 2, 32'h90001000, 0, 0, 3, exp_q.size() != 0, 0, 0);
        chk("nocred_stall", ready_o, 1'b0);
        step(0, 0, 0, 0, 0, 0, exp_q.size() != 0, 1, 0);
        step(1, 2, 32'h90001000, 0, 0, 3, exp_q.size() != 0, 0, 0);
        chk("cred_acc", ready_o, 1'b1);
        step(0, 0, 0, 0, 0, 0, exp_q.size() != 0, 1, 0);
        step(2, 2, 32'h90002000, 32'h77, 0, 4, exp_q.size() != 0, 1, 0);
        idle(1);
        chk("cred_same", out_credits_o, 5'd1);
        settle();

        // Exceptions: misaligned, local AMO, remote LR, back to back.
        step(1, 1, 32'h101, 0, 0, 1, 0, 0, 0);
        chk("mis_dmem_v", dmem_v_o, 1'b0);
        step(3, 2, 32'h10, 0, 0, 1, 0, 0, 0);
        chk("exc1_v", exception_v_o, 1'b1);
        chk("exc1_cause", exception_cause_o, 2'd1);
        step(4, 2, 32'h80000000, 0, 0, 1, 0, 0, 0);
        chk("exc2_cause", exception_cause_o, 2'd2);
        idle(1);
        chk("exc3_cause", exception_cause_o, 2'd3);
        chk("exc_norreq", remote_req_v_o, 1'b0);
        idle(1);

        // Reservation set by LR, killed by store to the same word.
        step(4, 2, 32'h20, 0, 0, 1, 0, 0, 0);
        idle(1);
        chk("res_set", reservation_v_o, 1'b1);
        chk("res_addr8", reservation_addr_o, 10'h8);
        step(2, 1, 32'h22, 32'hBEEF, 0, 1, 0, 0, 0);
        idle(1);
        chk("res_kill", reservation_v_o, 1'b0);

        // Randomised ops.
        for (int n = 0; n < 400; n++) begin
            op  = $urandom_range(0, 4);
            sz  = $urandom_range(0, 3);
            cls = $urandom_range(0, 3);
            case (cls)
                0:       a = $urandom_range(0, 'h3FF);
                1:       a = 32'h3F400 + $urandom_range(0, 'hBFF);
                2:       a = $urandom_range('h400, 'h3F3FF);
                default: a = $urandom | 32'h80000000;
            endcase
            if ($urandom_range(0, 3) != 0) a = (sz == 0) ? a : (sz == 1) ? (a & ~32'h1) : (a & ~32'h3);
            off = $urandom;
            step(op, sz, a - off, $urandom, off, $urandom_range(0, 31),
                 exp_q.size() != 0 && $urandom_range(0, 2) != 0,
                 credits_m < 16 && $urandom_range(0, 2) != 0,
                 $urandom_range(0, 15) == 0);
        end
        settle();

        // Asynchronous reset with two queued requests and a live reservation.
        step(4, 2, 32'h40, 0, 0, 1, 0, 0, 0);
        step(2, 2, 32'hA0000000, 32'h11, 0, 1, 0, 0, 0);
        step(2, 2, 32'hA0000004, 32'h22, 0, 2, 0, 0, 0);
        step(1, 0, 32'h3, 32'h1, 0, 3, 0, 0, 0);
        #2 reset_i = 1'b1;
        #1;
        chk("arst_rreq_v", remote_req_v_o, 1'b0);
        chk("arst_fence", fence_busy_o, 1'b0);
        chk("arst_credits", out_credits_o, 5'd16);
        chk("arst_res_v", reservation_v_o, 1'b0);
        chk("arst_exc_v", exception_v_o, 1'b0);
        @(negedge clk_i);
        v_i = 0; is_load_i = 0; is_store_i = 0; is_amo_i = 0; is_lr_i = 0;
        reset_i = 1'b0;
        model_reset();
        idle(3);
        step(2, 2, 32'hA0000008, 32'h33, 0, 4, 0, 0, 0);
        idle(1);
        settle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
